serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial ripple subtractor; the inverse operation of the team's parallel ripple-carry adder.
- Computes diff = a - b - b_in over WIDTH cycles, one bit per cycle, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Valid/ready handshake on both sides.
- Sits beside the adder blocks as the area-minimal arithmetic unit for the sequential datapath labs.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, b_in valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend (unsigned; two's complement for overflow)
b  input  WIDTH  subtrahend
b_in  input  1  borrow in
out_valid  output  1  diff/b_out valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - b_in mod 2^WIDTH
b_out  output  1  borrow out (1 when a < b + b_in, unsigned)

Behaviour:
- Reset (rst_n low, asynchronous; released synchronously by the design):
  - state = IDLE, out_valid = 0, diff = 0, b_out = 0, bit counter = 0, borrow FF = 0.
  - in_ready forced 0 while rst_n low.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready at an edge: latch a and b into shift registers, borrow FF <= b_in, counter <= 0, go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each edge processes bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br <= (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result register from the MSB side; counter increments.
    - After the edge processing i = WIDTH-1, go to DONE; b_out <= final borrow.
  - DONE: out_valid = 1, in_ready = 0. diff and b_out are held stable. On out_ready high at an edge: go to IDLE, out_valid drops next cycle.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge (WIDTH = 4 gives 4 cycles).
  - Minimum issue interval is WIDTH + 2 cycles.
- diff/b_out hold the last result in IDLE and RUN until overwritten. Consumers qualify with out_valid only.
- Inputs a, b, b_in are don't-care except on the accepting edge. Changes during RUN have no effect.
- in_valid in RUN or DONE is ignored; no queuing.
- out_ready outside DONE is ignored.
- Reset asserted in any state aborts the operation immediately. No partial result is emitted.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Optional Feature:
Macro SUB_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit).
  - ovf is the signed two's-complement overflow: the borrow into the MSB XOR the borrow out of the MSB.
  - ovf is registered at the same edge as b_out and valid with out_valid.
  - ovf resets to 0.
- Undefined: port ovf is absent and there is no overflow logic. All other behaviour is identical.

Test Plan:
- Basic: WIDTH=4, a=5, b=3, b_in=0.
  -> out_valid exactly 4 cycles after accept; diff=2, b_out=0.
- Borrow in: a=3, b=4, b_in=1.
  -> diff=14 (4'b1110), b_out=1.
- Full borrow: a=0, b=15, b_in=1.
  -> diff=0, b_out=1.
- Max operands: a=15, b=15, b_in=1.
  -> diff=15, b_out=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  -> diff and b_out stable, in_ready=0, new operands not accepted.
  -> On out_ready=1: IDLE next cycle, then the pending operands are accepted.
- Reset mid-RUN: pull rst_n low 2 cycles after accept.
  -> out_valid=0, diff=0, b_out=0 immediately; no result emitted.
  -> After release: a=10, b=1, b_in=1 yields diff=8, b_out=0.
- Overflow (SUB_OVERFLOW_EN): a=8, b=1, b_in=0 -> diff=7, ovf=1, b_out=0.
  a=7, b=15, b_in=0 -> diff=8, ovf=1, b_out=1.
  a=5, b=3, b_in=0 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - b_in, LSB first, one full-subtractor cell, valid/ready on both sides
// Ports: clk, rst_n (async active-low), in_valid/in_ready + a, b, b_in (operands),
//        out_valid/out_ready + diff, b_out (result), ovf (signed overflow, only with SUB_OVERFLOW_EN)
// Optional feature macro: SUB_OVERFLOW_EN
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             b_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [1:0] rst_s;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, res;
  logic br, d, nbr, last;
  assign d = sa[0] ^ sb[0] ^ br;
  assign nbr = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last = cnt == CW'(WIDTH - 1);
  // rst_s delays acceptance until reset release has been synchronised to clk
  assign in_ready = rst_n && rst_s[1] && state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rst_s <= '0;
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      res <= '0;
      br <= 1'b0;
      diff <= '0;
      b_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf <= 1'b0;
`endif
    end else begin
      rst_s <= {rst_s[0], 1'b1};
      if (in_valid && in_ready) begin
        sa <= a;
        sb <= b;
        br <= b_in;
        cnt <= '0;
        state <= RUN;
      end else if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= nbr;
        res <= {d, res[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        // diff is published only when complete so it holds the previous result during RUN
        if (last) begin
          state <= DONE;
          diff <= {d, res[WIDTH-1:1]};
          b_out <= nbr;
`ifdef SUB_OVERFLOW_EN
          ovf <= br ^ nbr;
`endif
        end
      end else if (state == DONE && out_ready) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, b_in = 0, out_valid, out_ready = 0, b_out, ovf;
  logic [3:0] a = 0, b = 0, diff;
  int checks = 0, errors = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
`ifdef SUB_OVERFLOW_EN
    .ovf(ovf),
`endif
    .b_out(b_out));

`ifndef SUB_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b;
    logic bi;
    logic [3:0] d;
    logic bo, ov;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference: plain integer arithmetic on unsigned and signed interpretations
  task automatic model(input logic [3:0] av, bv, input logic bi, output logic [3:0] d, output logic bo, ov);
    int sa, sb, r;
    d = 4'(int'(av) - int'(bv) - int'(bi));
    bo = int'(av) < int'(bv) + int'(bi);
    sa = av >= 8 ? int'(av) - 16 : int'(av);
    sb = bv >= 8 ? int'(bv) - 16 : int'(bv);
    r = sa - sb - int'(bi);
    ov = r < -8 || r > 7;
  endtask

  // drive operands at a negedge, accept on the next posedge, return at the following negedge
  task automatic issue(input logic [3:0] av, bv, input logic bi);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a = av; b = bv; b_in = bi; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    a = $urandom; b = $urandom; b_in = $urandom;
  endtask

  // count edges from accept until out_valid, compare result, optionally release it
  task automatic wait_result(input string name, input logic [3:0] d, input logic bo, ov, input bit rel);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_diff"}, diff, d);
    check({name, "_b_out"}, b_out, bo);
`ifdef SUB_OVERFLOW_EN
    check({name, "_ovf"}, ovf, ov);
`endif
    if (rel) begin
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      check({name, "_out_valid_drop"}, out_valid, 0);
    end
  endtask

  initial begin
    vec_t vt[6];
    logic [3:0] ed;
    logic eb, eo;
    vt[0] = '{4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0};
    vt[1] = '{4'd3, 4'd4, 1'b1, 4'd14, 1'b1, 1'b0};
    vt[2] = '{4'd0, 4'd15, 1'b1, 4'd0, 1'b1, 1'b0};
    vt[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vt[4] = '{4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1};
    vt[5] = '{4'd7, 4'd15, 1'b0, 4'd8, 1'b1, 1'b1};
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_diff", diff, 0);
    check("rst_b_out", b_out, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (vt[i]) begin
      issue(vt[i].a, vt[i].b, vt[i].bi);
      check("run_in_ready", in_ready, 0);
      wait_result($sformatf("vec%0d", i), vt[i].d, vt[i].bo, vt[i].ov, 1);
    end
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      logic rbi;
      ra = $urandom; rb = $urandom; rbi = $urandom;
      model(ra, rb, rbi, ed, eb, eo);
      issue(ra, rb, rbi);
      wait_result($sformatf("rand%0d", i), ed, eb, eo, 1);
    end
    // backpressure: new operands offered while the result waits must not be taken
    issue(4'd9, 4'd2, 1'b0);
    wait_result("bp_first", 4'd7, 1'b0, 1'b0, 0);
    in_valid = 1; a = 4'd6; b = 4'd1; b_in = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff", diff, 7);
      check("bp_b_out", b_out, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    check("bp_accepted", in_ready, 0);
    wait_result("bp_pending", 4'd5, 1'b0, 1'b0, 1);
    // reset two cycles into RUN aborts with no result
    issue(4'd12, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_b_out", b_out, 0);
    check("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_result", out_valid, 0);
    end
    issue(4'd10, 4'd1, 1'b1);
    wait_result("post_rst", 4'd8, 1'b0, 1'b0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
